// File: rtl/intpol2_d4_in_feeder.sv
// intpol2_d4_in_feeder: streams ilen samples from a sample memory
// (1-cycle read latency) into the interpolator input FIFO.
// A 2-entry output buffer absorbs the read latency, so the feeder sustains
// one word per cycle and never overruns when Afull_i or Full_i throttle it.
// Optional build macro: INTPOL2_D4_FEEDER_STALLCNT_EN adds the stall_cnt_o
// output, which counts the stalled cycles of the current transfer.
module intpol2_d4_in_feeder #(
  parameter int DATAPATH_WIDTH = 32,
  parameter int CONFIG_WIDTH   = 32,
  parameter int MEM_ADDR_WIDTH = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic [CONFIG_WIDTH-1:0]   ilen,
  output logic                      mem_rd_o,
  output logic [MEM_ADDR_WIDTH-1:0] mem_addr_o,
  input  logic [DATAPATH_WIDTH-1:0] mem_data_i,
  input  logic                      Afull_i,
  input  logic                      Full_i,
  output logic                      Write_Enable,
  output logic [DATAPATH_WIDTH-1:0] fifo_wdata_o,
  output logic                      busy,
  output logic                      stop_Afull,
  output logic                      done
`ifdef INTPOL2_D4_FEEDER_STALLCNT_EN
  ,
  output logic [CONFIG_WIDTH-1:0]   stall_cnt_o
`endif
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, FIN} state_t;

  state_t                    state_reg;
  logic [CONFIG_WIDTH-1:0]   ilen_reg;
  logic [CONFIG_WIDTH-1:0]   rd_cnt_reg;
  logic [CONFIG_WIDTH-1:0]   wr_cnt_reg;
  logic [MEM_ADDR_WIDTH-1:0] addr_reg;
  logic [1:0]                occ_reg;
  logic                      inflight_reg;
  logic [DATAPATH_WIDTH-1:0] head_reg;
  logic [DATAPATH_WIDTH-1:0] tail_reg;

  logic       issue;
  logic [2:0] pending;

  // Words already committed to the buffer: held entries plus the read
  // whose data lands this cycle, less the entry leaving this cycle.
  assign pending      = {1'b0, occ_reg} + {2'b00, inflight_reg};
  assign Write_Enable = (occ_reg != 2'd0) && !Full_i;
  assign issue        = (state_reg == RUN) && (rd_cnt_reg < ilen_reg) && !Afull_i &&
                        ((pending - {2'b00, Write_Enable}) < 3'd2);

  assign mem_rd_o     = issue;
  assign mem_addr_o   = issue ? rd_cnt_reg[MEM_ADDR_WIDTH-1:0] : addr_reg;
  assign fifo_wdata_o = head_reg;
  assign busy         = (state_reg != IDLE);
  assign done         = (state_reg == FIN);
  assign stop_Afull   = (state_reg == RUN) && (rd_cnt_reg < ilen_reg) && Afull_i;

  // Transfer control: state, latched length, read/write counters, last address.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg  <= IDLE;
      ilen_reg   <= '0;
      rd_cnt_reg <= '0;
      wr_cnt_reg <= '0;
      addr_reg   <= '0;
    end else begin
      if (Write_Enable) wr_cnt_reg <= wr_cnt_reg + 1'b1;
      case (state_reg)
        IDLE: begin
          if (start) begin
            ilen_reg   <= ilen;
            rd_cnt_reg <= '0;
            wr_cnt_reg <= '0;
            state_reg  <= (ilen == '0) ? FIN : RUN;
          end
        end
        RUN: begin
          if (issue) begin
            rd_cnt_reg <= rd_cnt_reg + 1'b1;
            addr_reg   <= rd_cnt_reg[MEM_ADDR_WIDTH-1:0];
            // Leave RUN on the edge that issues the final read.
            if (rd_cnt_reg + 1'b1 == ilen_reg) state_reg <= DRAIN;
          end
        end
        DRAIN: begin
          if (Write_Enable && (wr_cnt_reg + 1'b1 == ilen_reg)) state_reg <= FIN;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  // In-order 2-entry output buffer; read data is captured the cycle after issue.
  always_ff @(posedge clk) begin
    if (rst) begin
      occ_reg      <= 2'd0;
      inflight_reg <= 1'b0;
      head_reg     <= '0;
      tail_reg     <= '0;
    end else begin
      inflight_reg <= issue;
      case ({inflight_reg, Write_Enable})
        2'b10: begin
          if (occ_reg == 2'd0) head_reg <= mem_data_i;
          else                 tail_reg <= mem_data_i;
          occ_reg <= occ_reg + 2'd1;
        end
        2'b01: begin
          head_reg <= tail_reg;
          occ_reg  <= occ_reg - 2'd1;
        end
        2'b11: begin
          if (occ_reg == 2'd1) begin
            head_reg <= mem_data_i;
          end else begin
            head_reg <= tail_reg;
            tail_reg <= mem_data_i;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef INTPOL2_D4_FEEDER_STALLCNT_EN
  // Saturating count of cycles stalled by either FIFO flag during a transfer.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_o <= '0;
    end else if (state_reg == IDLE) begin
      if (start) stall_cnt_o <= '0;
    end else if ((stop_Afull || ((occ_reg != 2'd0) && Full_i)) && (stall_cnt_o != '1)) begin
      stall_cnt_o <= stall_cnt_o + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_intpol2_d4_in_feeder.sv
// Testbench for intpol2_d4_in_feeder: transaction-level model plus
// hand-computed timing pins for each directed scenario.
module tb_intpol2_d4_in_feeder;

  logic        clk = 1'b0;
  logic        rst, start, Afull_i, Full_i;
  logic [31:0] ilen;
  logic        mem_rd_o, Write_Enable, busy, stop_Afull, done;
  logic [15:0] mem_addr_o;
  logic [31:0] mem_data_i, fifo_wdata_o;
`ifdef INTPOL2_D4_FEEDER_STALLCNT_EN
  logic [31:0] stall_cnt;
`endif

  intpol2_d4_in_feeder dut (
    .clk(clk), .rst(rst), .start(start), .ilen(ilen),
    .mem_rd_o(mem_rd_o), .mem_addr_o(mem_addr_o), .mem_data_i(mem_data_i),
    .Afull_i(Afull_i), .Full_i(Full_i),
    .Write_Enable(Write_Enable), .fifo_wdata_o(fifo_wdata_o),
    .busy(busy), .stop_Afull(stop_Afull), .done(done)
`ifdef INTPOL2_D4_FEEDER_STALLCNT_EN
    , .stall_cnt_o(stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Memory contents as a function of address.
  function automatic logic [31:0] mem_word(input int unsigned a);
    logic [15:0] x;
    x = a[15:0];
    return {x ^ 16'hA5C3, x};
  endfunction

  // Sample memory: data valid exactly one cycle after the read strobe.
  initial begin
    logic        rd_seen;
    logic [15:0] a;
    mem_data_i = 32'hDEADBEEF;
    forever begin
      @(negedge clk);
      rd_seen = mem_rd_o;
      a       = mem_addr_o;
      @(posedge clk);
      #1;
      mem_data_i = (rd_seen === 1'b1) ? mem_word(a) : 32'hDEADBEEF;
    end
  end

  // Transaction model: one transfer reads and pushes words 0..ilen-1 in order.
  bit armed = 0, active = 0, done_due = 0, post_rst = 0;
  int m_ilen = 0, n_rd = 0, n_wr = 0;
  int first_rd_cyc, last_rd_cyc, first_we_cyc, last_we_cyc, done_cyc;
  int stop_count = 0, busy_cycles = 0, done_count = 0, last_addr = 0;

  initial begin
    forever begin
      @(negedge clk);
      if (armed) begin
        if (post_rst) begin
          chk("rst_mem_rd", mem_rd_o, 0);
          chk("rst_mem_addr", mem_addr_o, 0);
          chk("rst_we", Write_Enable, 0);
          chk("rst_wdata", fifo_wdata_o, 0);
          chk("rst_busy", busy, 0);
          chk("rst_stop", stop_Afull, 0);
          chk("rst_done", done, 0);
        end
        chk("busy", busy, active);
        chk("done", done, active && done_due);
        chk("stop_Afull", stop_Afull, active && !done_due && (n_rd < m_ilen) && Afull_i);
        chk("rd_allowed", mem_rd_o && !(active && !done_due && (n_rd < m_ilen) && !Afull_i), 0);
        chk("we_allowed", Write_Enable && (Full_i || !active || (n_wr >= n_rd)), 0);
        if (Write_Enable) begin
          chk("push_data", fifo_wdata_o, mem_word(n_wr));
          if (first_we_cyc < 0) first_we_cyc = cyc;
          last_we_cyc = cyc;
          n_wr++;
        end
        if (mem_rd_o) begin
          chk("rd_addr", mem_addr_o, n_rd % 65536);
          if (first_rd_cyc < 0) first_rd_cyc = cyc;
          last_rd_cyc = cyc;
          last_addr   = mem_addr_o;
          n_rd++;
        end
        chk("outstanding", ((n_rd - n_wr) <= 2), 1);
        if (stop_Afull) stop_count++;
        if (busy) busy_cycles++;
        if (done) begin
          done_count++;
          done_cyc = cyc;
        end
      end
      @(posedge clk);
      post_rst = rst;
      if (rst) begin
        armed    = 1;
        active   = 0;
        done_due = 0;
      end else if (!active) begin
        if (start) begin
          active = 1;
          m_ilen = int'(ilen);
          n_rd = 0; n_wr = 0;
          done_due = (ilen == 0);
          first_rd_cyc = -1; last_rd_cyc = -1; first_we_cyc = -1; last_we_cyc = -1;
          done_cyc = -1; stop_count = 0; busy_cycles = 0;
        end
      end else if (done_due) begin
        active   = 0;
        done_due = 0;
      end else if (n_wr == m_ilen) begin
        done_due = 1;
      end
    end
  end

  int s;

  // mode 0: free flow; 1: Full_i high for cycles 3..12; 2: Afull_i on odd cycles.
  // Extra start pulses at cycles 1 and 4 must be ignored.
  task automatic run_xfer(input int len, input int mode, input int budget);
    int d0;
    d0 = done_count;
    @(posedge clk); #1;
    ilen = len; start = 1; Afull_i = 0; Full_i = 0;
    s = cyc;
    for (int k = 1; k <= budget; k++) begin
      @(posedge clk); #1;
      start   = (k == 1 || k == 4);
      ilen    = 32'd3;
      Afull_i = (mode == 2) ? k[0] : 1'b0;
      Full_i  = (mode == 1) && (k >= 3) && (k <= 12);
      if (done_count != d0) break;
    end
    start = 0; Afull_i = 0; Full_i = 0;
    chk("one_done", done_count - d0, 1);
    $display("xfer len=%0d mode=%0d start=%0d done=%0d pushes=%0d", len, mode, s, done_cyc, n_wr);
  endtask

  initial begin
    rst = 1; start = 0; ilen = 0; Afull_i = 0; Full_i = 0;
    repeat (3) @(posedge clk);
    #1 rst = 0;
    @(posedge clk); #1;

    // Free-flowing 8-word transfer.
    run_xfer(8, 0, 40);
    chk("t8_first_rd", first_rd_cyc, s + 1);
    chk("t8_last_rd", last_rd_cyc, s + 8);
    chk("t8_first_we", first_we_cyc, s + 3);
    chk("t8_last_we", last_we_cyc, s + 10);
    chk("t8_done", done_cyc, s + 11);
    chk("t8_pushes", n_wr, 8);
    chk("t8_busy", busy_cycles, 11);
    chk("t8_stop", stop_count, 0);

    // Zero-length transfer.
    run_xfer(0, 0, 20);
    chk("t0_done", done_cyc, s + 1);
    chk("t0_reads", n_rd, 0);
    chk("t0_pushes", n_wr, 0);
    chk("t0_busy", busy_cycles, 1);

    // Full_i held for 10 cycles.
    run_xfer(16, 1, 80);
    chk("tf_first_we", first_we_cyc, s + 13);
    chk("tf_done", done_cyc, s + 29);
    chk("tf_pushes", n_wr, 16);
`ifdef INTPOL2_D4_FEEDER_STALLCNT_EN
    chk("tf_stall_ge10", stall_cnt >= 10, 1);
`endif

    // Afull_i toggling every other cycle.
    run_xfer(16, 2, 80);
    chk("ta_first_rd", first_rd_cyc, s + 2);
    chk("ta_done", done_cyc, s + 35);
    chk("ta_stop", stop_count, 16);
    chk("ta_pushes", n_wr, 16);

    // Reset asserted during the 6th push, then a clean 4-word transfer.
    begin
      int d0;
      d0 = done_count;
      @(posedge clk); #1;
      ilen = 12; start = 1;
      @(posedge clk); #1;
      start = 0;
      for (int k = 0; k < 40; k++) begin
        @(negedge clk); #1;
        if (n_wr == 6) break;
      end
      chk("tr_six_pushes", n_wr, 6);
      rst = 1;
      @(posedge clk); #1;
      rst = 0;
      @(negedge clk);
      chk("tr_busy_after", busy, 0);
      chk("tr_we_after", Write_Enable, 0);
      repeat (3) @(posedge clk);
      chk("tr_no_done", done_count, d0);
      $display("reset mid-transfer at cycle %0d", cyc);
    end
    run_xfer(4, 0, 30);
    chk("tr4_first_rd", first_rd_cyc, s + 1);
    chk("tr4_done", done_cyc, s + 7);
    chk("tr4_pushes", n_wr, 4);

    // Long transfer: address wraps past 65535.
    run_xfer(70000, 0, 70100);
    chk("tw_pushes", n_wr, 70000);
    chk("tw_done", done_cyc, s + 70003);
    chk("tw_last_addr", last_addr, 4463);

    repeat (4) @(posedge clk);
    chk("done_total", done_count, 6);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/intpol2_d4_in_feeder.md
INTPOL2_D4_IN_FEEDER -- requirements
Module: intpol2_D4_in_feeder

Interface
REQ-001 Parameter DATAPATH_WIDTH, default 32, sample word width.
REQ-002 Parameter CONFIG_WIDTH, default 32, width of ilen and internal counters.
REQ-003 Parameter MEM_ADDR_WIDTH, default 16, sample-memory address width.
REQ-004 clk  input  1  single clock; all logic rising-edge.
REQ-005 rst  input  1  reset, synchronous, active-high.
REQ-006 start  input  1  one-cycle request to begin a transfer.
REQ-007 ilen  input  CONFIG_WIDTH  number of samples to transfer; sampled on accepted start.
REQ-008 mem_rd_o  output  1  sample-memory read strobe.
REQ-009 mem_addr_o  output  MEM_ADDR_WIDTH  sample-memory read address.
REQ-010 mem_data_i  input  DATAPATH_WIDTH  read data, valid exactly 1 cycle after mem_rd_o.
REQ-011 Afull_i  input  1  interpolator input FIFO almost-full.
REQ-012 Full_i  input  1  interpolator input FIFO full.
REQ-013 Write_Enable  output  1  FIFO push strobe.
REQ-014 fifo_wdata_o  output  DATAPATH_WIDTH  FIFO push data.
REQ-015 busy  output  1  transfer in progress.
REQ-016 stop_Afull  output  1  high while in RUN and read issue is blocked by Afull_i.
REQ-017 done  output  1  one-cycle pulse at transfer completion.

Function
REQ-018 FSM states IDLE, RUN, DRAIN, FIN; IDLE after reset.
REQ-019 IDLE: start=1 latches ilen, clears rd_cnt and wr_cnt; goes to FIN if ilen==0, else RUN.
REQ-020 start SHALL be ignored in every state except IDLE.
REQ-021 Read issue condition (RUN only): rd_cnt<ilen_q AND Afull_i==0 AND (occ + inflight - Write_Enable) < 2, where occ = output-buffer entries, inflight = read issued previous cycle.
REQ-022 On issue: mem_rd_o=1, mem_addr_o = rd_cnt[MEM_ADDR_WIDTH-1:0] (wraps modulo 2^MEM_ADDR_WIDTH), rd_cnt increments.
REQ-023 mem_rd_o=0 and mem_addr_o holds last value when not issuing.
REQ-024 mem_data_i captured into a 2-entry in-order output buffer the cycle after issue.
REQ-025 Write_Enable = (occ>0) AND Full_i==0, combinational; fifo_wdata_o = buffer head; head pops when Write_Enable=1.
REQ-026 Capture and pop in the same cycle SHALL both occur; occ unchanged.
REQ-027 Buffer SHALL never overflow and no sample SHALL be dropped or duplicated, for any Afull_i/Full_i pattern.
REQ-028 Steady-state throughput 1 word/cycle when Afull_i=Full_i=0; first Write_Enable 2 cycles after leaving IDLE.
REQ-029 RUN -> DRAIN when rd_cnt==ilen_q; DRAIN -> FIN when wr_cnt==ilen_q (occ=0, inflight=0).
REQ-030 FIN: done=1 for exactly one cycle, then IDLE.
REQ-031 busy=1 in RUN, DRAIN, FIN; 0 in IDLE.
REQ-032 ilen change while busy SHALL have no effect.
REQ-033 Samples pushed in ascending address order 0..ilen_q-1.

Reset
REQ-034 rst=1 SHALL, at the next clock edge, force IDLE, clear rd_cnt, wr_cnt, occ, inflight, regardless of state.
REQ-035 Reset values: mem_rd_o=0, mem_addr_o=0, Write_Enable=0, fifo_wdata_o=0, busy=0, stop_Afull=0, done=0.
REQ-036 Reset mid-transfer SHALL discard buffered and in-flight data; no done pulse.

Configuration
REQ-037 Macro INTPOL2_D4_FEEDER_STALLCNT_EN defined: extra output stall_cnt_o (CONFIG_WIDTH) counts cycles with stop_Afull=1 or (occ>0 AND Full_i=1); cleared on accepted start, saturates at all-ones, holds in IDLE, reset to 0.
REQ-038 Macro undefined: port stall_cnt_o and its logic absent; all other behaviour identical.

Verification
REQ-039 ilen=8, Afull_i=Full_i=0, start -> mem_rd_o 8 consecutive cycles addr 0..7; 8 consecutive Write_Enable with data mem[0..7]; done pulse 1 cycle after last push.
REQ-040 ilen=0, start -> busy high 1 cycle, done pulse, no mem_rd_o, no Write_Enable.
REQ-041 ilen=16, Full_i held 1 for 10 cycles from cycle 3 -> no overflow, 16 pushes in order, stall_cnt_o>=10 when macro defined.
REQ-042 ilen=16, Afull_i toggled every other cycle -> stop_Afull tracks blocked cycles, all 16 samples pushed in order exactly once.
REQ-043 ilen=12, rst=1 at 6th push -> next cycle all outputs at reset values; new start ilen=4 then transfers addr 0..3 cleanly.
REQ-044 ilen=70000 with MEM_ADDR_WIDTH=16 -> mem_addr_o wraps 65535->0, 70000 pushes, single done.
